// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - field width, wrap limits, set-mode FSM state type and wrap-increment helper
package clock_pkg;

    localparam int FIELD_W = 7;

    localparam logic [FIELD_W-1:0] HRS_MAX     = 7'd23;
    localparam logic [FIELD_W-1:0] MIN_SEC_MAX = 7'd59;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SET_HRS,
        ST_SET_MINS,
        ST_SET_SECS
    } set_state_t;

    // Values already past the limit (captured from a misbehaving counter) also wrap to zero.
    function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] value,
                                                    input logic [FIELD_W-1:0] max_value);
        return (value >= max_value) ? '0 : value + 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchronizer, counter debouncer and press pulse for one active-low key
module key_debounce #(
    parameter int DEBOUNCE_TC = 499999
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_TC > 0) ? $clog2(DEBOUNCE_TC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_TC);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            level_o <= 1'b1;
            cnt_q   <= '0;
            press_o <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            press_o <= 1'b0;
            // Level flips once the synchronized input has disagreed for CNT_TC+1 cycles in a row.
            if (sync_q[1] != level_o) begin
                if (cnt_q == CNT_TC) begin
                    level_o <= sync_q[1];
                    cnt_q   <= '0;
                    press_o <= ~sync_q[1];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - clock time-set controller; TIME_SET_AUTOREPEAT_EN enables held-key auto-repeat
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_TC = 499999,
    parameter int BLINK_TC    = 24999999,
    parameter int REPEAT_TC   = 12499999
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               nMode_i,
    input  logic               nInc_i,
    input  logic [FIELD_W-1:0] hrs_i,
    input  logic [FIELD_W-1:0] mins_i,
    input  logic [FIELD_W-1:0] secs_i,
    output logic [FIELD_W-1:0] hrs_o,
    output logic [FIELD_W-1:0] mins_o,
    output logic [FIELD_W-1:0] secs_o,
    output logic               load_o,
    output logic               run_o,
    output logic [2:0]         blink_o
);

    localparam int BLK_W = (BLINK_TC > 0) ? $clog2(BLINK_TC + 1) : 1;
    localparam logic [BLK_W-1:0] BLK_TC = BLK_W'(BLINK_TC);

    set_state_t state_q, state_d;
    logic mode_press, inc_press;
    logic mode_level, inc_level;
    logic inc_step;
    logic entering_set;
    logic [BLK_W-1:0] blink_cnt_q;
    logic blink_phase_q;

    logic unused_mode_level;
    assign unused_mode_level = mode_level;

    key_debounce #(.DEBOUNCE_TC(DEBOUNCE_TC)) u_mode_key (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .key_n_i (nMode_i),
        .level_o (mode_level),
        .press_o (mode_press)
    );

    key_debounce #(.DEBOUNCE_TC(DEBOUNCE_TC)) u_inc_key (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .key_n_i (nInc_i),
        .level_o (inc_level),
        .press_o (inc_press)
    );

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int REP_W = (REPEAT_TC > 0) ? $clog2(REPEAT_TC + 1) : 1;
    localparam logic [REP_W-1:0] REP_TC = REP_W'(REPEAT_TC);

    logic [REP_W-1:0] rep_cnt_q;
    logic rep_fire;

    assign rep_fire = (state_q != ST_RUN) && !inc_level && !inc_press && (rep_cnt_q == REP_TC);

    // Restarts on every press so the first repeat lands REPEAT_TC+1 cycles after it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rep_cnt_q <= '0;
        end else if (inc_press || inc_level || mode_press || state_q == ST_RUN) begin
            rep_cnt_q <= '0;
        end else if (rep_cnt_q == REP_TC) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
        end
    end

    assign inc_step = (inc_press || rep_fire) && !mode_press && (state_q != ST_RUN);
`else
    localparam int unused_repeat_tc = REPEAT_TC;
    logic unused_inc_level;
    assign unused_inc_level = inc_level;

    assign inc_step = inc_press && !mode_press && (state_q != ST_RUN);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (mode_press) state_d = ST_SET_HRS;
            ST_SET_HRS:  if (mode_press) state_d = ST_SET_MINS;
            ST_SET_MINS: if (mode_press) state_d = ST_SET_SECS;
            ST_SET_SECS: if (mode_press) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hrs_o  <= '0;
            mins_o <= '0;
            secs_o <= '0;
        end else if (state_q == ST_RUN && mode_press) begin
            hrs_o  <= hrs_i;
            mins_o <= mins_i;
            secs_o <= secs_i;
        end else if (inc_step) begin
            case (state_q)
                ST_SET_HRS:  hrs_o  <= wrap_inc(hrs_o, HRS_MAX);
                ST_SET_MINS: mins_o <= wrap_inc(mins_o, MIN_SEC_MAX);
                ST_SET_SECS: secs_o <= wrap_inc(secs_o, MIN_SEC_MAX);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            load_o <= 1'b0;
        end else begin
            load_o <= (state_q == ST_SET_SECS) && mode_press;
        end
    end

    assign run_o = (state_q == ST_RUN);

    assign entering_set = (state_d != state_q) && (state_d != ST_RUN);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (entering_set) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLK_TC) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    always_comb begin
        blink_o = 3'b000;
        case (state_q)
            ST_SET_HRS:  blink_o = {blink_phase_q, 2'b00};
            ST_SET_MINS: blink_o = {1'b0, blink_phase_q, 1'b0};
            ST_SET_SECS: blink_o = {2'b00, blink_phase_q};
            default:     blink_o = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - table-driven and scoreboard bench for time_set_ctrl
module tb_time_set_ctrl;

    localparam int DTC = 3;
    localparam int BTC = 7;
    localparam int RTC = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       n_mode, n_inc;
    logic [6:0] hrs_i, mins_i, secs_i;
    logic [6:0] hrs_o, mins_o, secs_o;
    logic       load_o, run_o;
    logic [2:0] blink_o;

    time_set_ctrl #(.DEBOUNCE_TC(DTC), .BLINK_TC(BTC), .REPEAT_TC(RTC)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .nMode_i (n_mode),
        .nInc_i  (n_inc),
        .hrs_i   (hrs_i),
        .mins_i  (mins_i),
        .secs_i  (secs_i),
        .hrs_o   (hrs_o),
        .mins_o  (mins_o),
        .secs_o  (secs_o),
        .load_o  (load_o),
        .run_o   (run_o),
        .blink_o (blink_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int loads = 0;
    logic prev_load = 1'b0;

    typedef struct {
        logic [6:0] h;
        logic [6:0] m;
        logic [6:0] s;
    } exp_t;
    exp_t load_q[$];

    typedef struct {
        logic       m;
        logic       i;
        int         low;
        logic [6:0] in_h, in_m, in_s;
        logic       push;
        logic [6:0] eh, em, es;
        logic       erun;
    } vec_t;
    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tap(input logic m, input logic i, input int low);
        @(negedge clk);
        n_mode = ~m;
        n_inc  = ~i;
        repeat (low) @(negedge clk);
        n_mode = 1'b1;
        n_inc  = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Scoreboard side: every load pulse pops the value pushed when the final mode press was driven.
    always @(negedge clk) begin
        exp_t e;
        if (load_o) begin
            loads++;
            check("load single cycle", int'(prev_load), 0);
            if (load_q.size() == 0) begin
                check("unexpected load", 1, 0);
            end else begin
                e = load_q.pop_front();
                check("load hrs", hrs_o, e.h);
                check("load mins", mins_o, e.m);
                check("load secs", secs_o, e.s);
                check("load run", run_o, 1);
            end
        end
        prev_load = load_o;
    end

    initial begin
        int rep_q[$];
        int last, first_t, last_chg, e_idx;
        logic [6:0] final_secs;
        logic [2:0] prev_blink;
        logic [2:0] bs[64];
        logic found;

        vecs[0]  = '{1'b1, 1'b0, 10, 7'd23, 7'd59, 7'd58, 1'b0, 7'd23, 7'd59, 7'd58, 1'b0};
        vecs[1]  = '{1'b0, 1'b1,  3, 7'd23, 7'd59, 7'd58, 1'b0, 7'd23, 7'd59, 7'd58, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 10, 7'd23, 7'd59, 7'd58, 1'b0, 7'd0,  7'd59, 7'd58, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 10, 7'd23, 7'd59, 7'd58, 1'b0, 7'd0,  7'd59, 7'd58, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 10, 7'd23, 7'd59, 7'd58, 1'b0, 7'd0,  7'd0,  7'd58, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 10, 7'd23, 7'd59, 7'd58, 1'b0, 7'd0,  7'd0,  7'd58, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 10, 7'd23, 7'd59, 7'd58, 1'b1, 7'd0,  7'd0,  7'd58, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 10, 7'd23, 7'd59, 7'd58, 1'b0, 7'd0,  7'd0,  7'd58, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 10, 7'd30, 7'd60, 7'd57, 1'b0, 7'd30, 7'd60, 7'd57, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 10, 7'd30, 7'd60, 7'd57, 1'b0, 7'd0,  7'd60, 7'd57, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 10, 7'd30, 7'd60, 7'd57, 1'b0, 7'd0,  7'd60, 7'd57, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 10, 7'd30, 7'd60, 7'd57, 1'b0, 7'd0,  7'd0,  7'd57, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 10, 7'd30, 7'd60, 7'd57, 1'b0, 7'd0,  7'd0,  7'd57, 1'b0};

        rst = 1'b1;
        n_mode = 1'b1;
        n_inc = 1'b1;
        hrs_i = 7'd23;
        mins_i = 7'd59;
        secs_i = 7'd58;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset run", run_o, 1);
        check("reset load", load_o, 0);
        check("reset blink", blink_o, 0);
        check("reset hrs", hrs_o, 0);
        check("reset mins", mins_o, 0);
        check("reset secs", secs_o, 0);

        for (int k = 0; k < 13; k++) begin
            hrs_i = vecs[k].in_h;
            mins_i = vecs[k].in_m;
            secs_i = vecs[k].in_s;
            if (vecs[k].push) load_q.push_back('{vecs[k].eh, vecs[k].em, vecs[k].es});
            tap(vecs[k].m, vecs[k].i, vecs[k].low);
            check($sformatf("row%0d hrs", k), hrs_o, vecs[k].eh);
            check($sformatf("row%0d mins", k), mins_o, vecs[k].em);
            check($sformatf("row%0d secs", k), secs_o, vecs[k].es);
            check($sformatf("row%0d run", k), run_o, vecs[k].erun);
        end

        // Held inc in SET_SECS starting at 57.
`ifdef TIME_SET_AUTOREPEAT_EN
        rep_q = '{58, 59, 0, 1, 2};
        final_secs = 7'd2;
`else
        rep_q = '{58};
        final_secs = 7'd58;
`endif
        last = secs_o;
        first_t = -1;
        last_chg = 0;
        @(negedge clk);
        n_inc = 1'b0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (first_t >= 0 && t == first_t + 20) n_inc = 1'b1;
            if (int'(secs_o) != last) begin
                last = secs_o;
                if (first_t < 0) first_t = t;
                else check("repeat spacing", t - last_chg, RTC + 1);
                last_chg = t;
                if (rep_q.size() == 0) check("repeat extra step", secs_o, 999);
                else check("repeat value", secs_o, rep_q.pop_front());
            end
        end
        n_inc = 1'b1;
        check("repeat saw first step", int'(first_t >= 0), 1);
        check("repeat missing steps", rep_q.size(), 0);

        load_q.push_back('{7'd0, 7'd0, final_secs});
        tap(1'b1, 1'b0, 10);
        check("final run", run_o, 1);
        check("final secs", secs_o, final_secs);

        // Blink: leave SET_HRS while its phase is high, then watch SET_MINS.
        tap(1'b1, 1'b0, 10);
        check("set_hrs run", run_o, 0);
        found = 1'b0;
        prev_blink = blink_o;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge clk);
            if (prev_blink == 3'b000 && blink_o == 3'b100) found = 1'b1;
            prev_blink = blink_o;
        end
        check("hrs blink rise seen", found, 1);
        n_mode = 1'b0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (t == 10) n_mode = 1'b1;
            bs[t] = blink_o;
        end
        e_idx = -1;
        for (int t = 0; t < 64; t++) if (e_idx < 0 && bs[t] == 3'b000) e_idx = t;
        check("mins entry seen", int'(e_idx >= 0 && e_idx <= 32), 1);
        if (e_idx >= 0 && e_idx <= 32) begin
            for (int j = 0; j < 32; j++)
                check($sformatf("mins blink %0d", j), bs[e_idx + j], ((j / 8) % 2) ? 3'b010 : 3'b000);
        end

        // Reset in SET_MINS drops edits with no load.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst set run", run_o, 1);
        check("rst set blink", blink_o, 0);
        check("rst set hrs", hrs_o, 0);
        check("rst set mins", mins_o, 0);

        // Simultaneous mode+inc in SET_HRS.
        hrs_i = 7'd5;
        mins_i = 7'd10;
        secs_i = 7'd20;
        tap(1'b1, 1'b0, 10);
        check("simul pre hrs", hrs_o, 5);
        tap(1'b1, 1'b1, 10);
        check("simul hrs kept", hrs_o, 5);
        check("simul mins kept", mins_o, 10);
        tap(1'b0, 1'b1, 10);
        check("simul now mins", mins_o, 11);
        check("simul hrs still", hrs_o, 5);
        check("simul blink field", blink_o[2], 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst2 run", run_o, 1);
        check("rst2 mins", mins_o, 0);
        check("load count", loads, 2);
        check("load queue empty", load_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_TC, default 499999, debounce terminal count (10 ms at 50 MHz).
REQ-002 SHALL have parameter BLINK_TC, default 24999999, blink half-period terminal count (0.5 s).
REQ-003 SHALL have parameter REPEAT_TC, default 12499999, auto-repeat terminal count; used only when TIME_SET_AUTOREPEAT_EN is defined.
REQ-004 clk_i  in  1  single system clock; all logic in this one domain.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 nMode_i  in  1  raw mode key, active-low, asynchronous to clk_i.
REQ-007 nInc_i  in  1  raw increment key, active-low, asynchronous to clk_i.
REQ-008 hrs_i / mins_i / secs_i  in  7 each  live time from the downstream clock counter.
REQ-009 hrs_o / mins_o / secs_o  out  7 each  load values for the clock counter.
REQ-010 load_o  out  1  one-cycle strobe: counter loads hrs_o/mins_o/secs_o.
REQ-011 run_o  out  1  counter count-enable.
REQ-012 blink_o  out  3  display blank mask: [2] hours, [1] minutes, [0] seconds.

Function
REQ-013 Each key SHALL pass a 2-flop synchronizer, then a debouncer. The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_TC+1 consecutive cycles.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition. Releases generate no event.
REQ-015 FSM states SHALL be RUN, SET_HRS, SET_MINS, SET_SECS.
REQ-016 RUN + mode press SHALL capture hrs_i/mins_i/secs_i into the shadow registers, go to SET_HRS, and drive run_o low on the next cycle.
REQ-017 SET_HRS + mode press SHALL go to SET_MINS; SET_MINS + mode press SHALL go to SET_SECS.
REQ-018 SET_SECS + mode press SHALL go to RUN, with load_o=1 for exactly the first RUN cycle and run_o=1 from that same cycle.
REQ-019 An inc press in a SET state SHALL add 1 to the selected shadow field: hours wrap 23->0, minutes and seconds wrap 59->0. Out-of-range captured values (>23 or >59) SHALL wrap to 0 on increment.
REQ-020 An inc press in RUN SHALL be ignored.
REQ-021 Mode press and inc press in the same cycle: mode SHALL win, and the inc SHALL be dropped.
REQ-022 hrs_o/mins_o/secs_o SHALL always equal the shadow registers.
REQ-023 load_o SHALL never be asserted outside REQ-018.
REQ-024 Blink phase SHALL toggle every BLINK_TC+1 cycles and clear to 0 on entry to any SET state. In a SET state, only the selected field's blink_o bit SHALL equal the phase. In RUN, blink_o=000.

Reset
REQ-025 On rst_i: state RUN; shadow=0; load_o=0; run_o=1; blink_o=000; debounced keys released (1); all counters 0.
REQ-026 Reset during a SET state SHALL return to RUN with no load_o pulse and discard pending edits.

Configuration
REQ-027 With TIME_SET_AUTOREPEAT_EN defined, holding inc in a SET state SHALL produce the first increment on press, then one increment every REPEAT_TC+1 cycles while held.
REQ-028 Without TIME_SET_AUTOREPEAT_EN, each press SHALL give exactly one increment, and no repeat counter SHALL exist.

Structure
REQ-029 Package clock_pkg SHALL hold: the field width (7), HRS_MAX=23, MIN_SEC_MAX=59, and the FSM state enum type.
REQ-030 Sub-module key_debounce (synchronizer + debouncer + press pulse, parameter DEBOUNCE_TC) SHALL be instantiated once per key.

Verification (DEBOUNCE_TC=3, BLINK_TC=7, REPEAT_TC=5)
REQ-031 Assert rst_i, release -> run_o=1, load_o=0, blink_o=000, all time outputs 0.
REQ-032 nInc_i low 3 cycles in SET_HRS -> no increment. Low 10 cycles -> exactly one increment.
REQ-033 hrs_i=23, mins_i=59, secs_i=58. Sequence: mode, inc, mode, inc, mode, mode -> single-cycle load_o with 0/0/58, run_o=1.
REQ-034 Hold in SET_MINS 32 cycles -> blink_o alternates 000/010 every 8 cycles, starting at 000.
REQ-035 Mode+inc press events in the same cycle in SET_HRS -> state SET_MINS, hrs_o unchanged. rst_i in SET_MINS -> RUN, load_o never asserted.
REQ-036 With TIME_SET_AUTOREPEAT_EN, inc held 30 cycles after debounce in SET_SECS from 57 -> 57,58,59,0,1,2 (one step per 6 cycles). Without the macro -> 58 only.
